// File: rtl/combo_lock_if.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : combo_lock_if                                               |
// | Purpose  : Bundles the conditioned button pulses, the digit switches   |
// |            and the lock status outputs of combo_lock_fsm.              |
// | Signals  : Digit[3:0], EnterPulse, ClearPulse, ProgPulse  (to lock)    |
// |            Unlocked, Error, LockedOut, DigitCount, FailCount (from)    |
// | Modports : master - drives the pulses (button conditioners / bench)    |
// |            slave  - the lock state machine                             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface combo_lock_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_FAILS  = 3
);
  logic [3:0]                       Digit;
  logic                             EnterPulse;
  logic                             ClearPulse;
  logic                             ProgPulse;
  logic                             Unlocked;
  logic                             Error;
  logic                             LockedOut;
  logic [$clog2(NUM_DIGITS+1)-1:0]  DigitCount;
  logic [$clog2(MAX_FAILS+1)-1:0]   FailCount;

  modport master (
    output Digit, EnterPulse, ClearPulse, ProgPulse,
    input  Unlocked, Error, LockedOut, DigitCount, FailCount
  );

  modport slave (
    input  Digit, EnterPulse, ClearPulse, ProgPulse,
    output Unlocked, Error, LockedOut, DigitCount, FailCount
  );
endinterface
`default_nettype wire

// File: rtl/combo_lock_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : combo_lock_fsm                                              |
// | Purpose  : Combination lock controller. Collects NUM_DIGITS digits,    |
// |            compares them with the stored code, opens / flags errors /  |
// |            locks out after MAX_FAILS consecutive misses, and allows    |
// |            reprogramming of the code while open.                       |
// | Ports    : Clock  - system clock, rising edge                          |
// |            Resetn - synchronous active-low reset                       |
// |            bus    - combo_lock_if.slave: Digit, Enter/Clear/ProgPulse  |
// |                     in; Unlocked, Error, LockedOut, DigitCount,        |
// |                     FailCount out                                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module combo_lock_fsm #(
  parameter int                      NUM_DIGITS     = 4,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 100
) (
  input  logic         Clock,
  input  logic         Resetn,
  combo_lock_if.slave  bus
);

  localparam int CODE_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0] LAST_FAIL  = FAIL_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0]  LAST_TICK  = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   entry_q, entry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                err_pend_q, err_pend_d;
  logic                unlocked_q, unlocked_d;
  logic                error_q, error_d;
  logic                locked_out_q, locked_out_d;
  logic [CODE_W-1:0]   shifted_entry;

  // First-entered digit ends up in the most-significant nibble.
  assign shifted_entry = (entry_q << 4) | CODE_W'(bus.Digit);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    tmr_d      = tmr_q;
    err_pend_d = 1'b0;

    case (state_q)
      ST_LOCKED, ST_PROG: begin
        if (bus.ClearPulse) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (bus.EnterPulse) begin
          if (cnt_q == LAST_DIGIT) begin
            if (state_q == ST_PROG) begin
              code_d  = shifted_entry;
              entry_d = '0;
              cnt_d   = '0;
              state_d = ST_LOCKED;
            end else begin
              entry_d = shifted_entry;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_CHECK;
            end
          end else begin
            entry_d = shifted_entry;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == code_q) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else begin
          err_pend_d = 1'b1;
          fail_d     = fail_q + FAIL_W'(1);
          state_d    = (fail_q == LAST_FAIL) ? ST_LOCKOUT : ST_LOCKED;
        end
      end

      ST_OPEN: begin
        if (bus.ProgPulse) begin
          state_d = ST_PROG;
        end else if (bus.EnterPulse) begin
          state_d = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_q == LAST_TICK) begin
          tmr_d   = '0;
          fail_d  = '0;
          state_d = ST_LOCKED;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase

    // Status outputs are registered decodes of the current state, so they
    // trail the state register by one cycle and see no input directly.
    unlocked_d   = (state_q == ST_OPEN) || (state_q == ST_PROG);
    locked_out_d = (state_q == ST_LOCKOUT);
    error_d      = err_pend_q;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= ST_LOCKED;
      code_q       <= DEFAULT_CODE;
      entry_q      <= '0;
      cnt_q        <= '0;
      fail_q       <= '0;
      tmr_q        <= '0;
      err_pend_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      entry_q      <= entry_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      tmr_q        <= tmr_d;
      err_pend_q   <= err_pend_d;
      unlocked_q   <= unlocked_d;
      error_q      <= error_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign bus.Unlocked   = unlocked_q;
  assign bus.Error      = error_q;
  assign bus.LockedOut  = locked_out_q;
  assign bus.DigitCount = cnt_q;
  assign bus.FailCount  = fail_q;

endmodule
`default_nettype wire
